out_pkt_fifo: RTL and testbench
===============================

# out_pkt_fifo

Parametrised packet-aware USB full-speed OUT FIFO sitting between the SIE and the application, both in the `clk_i` domain. Bytes of an OUT transaction are written speculatively and become visible to the application only when the SIE ends the transaction cleanly; errored transactions are rolled back. Admission is decided per packet: a packet is NAKed whole unless a maximum-size packet fits. The application side delivers 1, 2 or 4 bytes per beat, with byte-keep and packet-end marking.

## Interface
- `OUT_MAXPACKETSIZE`, default 64: largest accepted packet in bytes, range 8..64.
- `FIFO_DEPTH`, default 128: byte storage entries, any value ≥ `OUT_MAXPACKETSIZE`, not necessarily a power of 2.
- `APP_BYTES`, default 1: bytes per application beat, one of 1, 2, 4.
- `clk_i` in 1: 12 MHz × BIT_SAMPLES clock.
- `rst_i` in 1: reset. **One clock; reset is synchronous and active-high.**
- `out_data_i` in 8: SIE byte.
- `out_valid_i` in 1: byte valid.
- `out_err_i` in 1: abort current packet.
- `out_ready_i` in 1: single-cycle SIE strobe.
- `out_nak_o` out 1: current/last transaction NAKed.
- `out_empty_o` out 1: committed count = 0.
- `out_full_o` out 1: free space < `OUT_MAXPACKETSIZE`.
- `app_out_data_o` out 8·APP_BYTES: byte 0 in bits [7:0] is the oldest.
- `app_out_keep_o` out APP_BYTES: per-byte valid, contiguous from bit 0.
- `app_out_last_o` out 1: beat holds the final byte of a packet.
- `app_out_valid_o` out 1: beat valid; it is held stable until consumed.
- `app_out_ready_i` in 1: a beat is consumed when valid & ready.

## Operation
- Storage: circular array of `FIFO_DEPTH` entries, each 8 data bits plus 1 last tag.
- Pointers: `rd_ptr`, committed `wr_ptr`, speculative `spec_ptr`. Each wraps from `FIFO_DEPTH-1` to 0.
- Counters: committed `cnt`, width clog2(FIFO_DEPTH+1). Packet byte counter `pkt_len`, width clog2(OUT_MAXPACKETSIZE+1).
- The FSM advances only on `out_ready_i`. States are IDLE, DATA, NAK.
  - IDLE, valid, free ≥ `OUT_MAXPACKETSIZE`: write the byte at `spec_ptr`, `pkt_len` = 1, go to DATA, `out_nak_o` = 0.
  - IDLE, valid, free < `OUT_MAXPACKETSIZE`: no write, go to NAK, `out_nak_o` = 1.
  - DATA, valid, `pkt_len` < MAX: write the byte, increment `pkt_len`.
  - DATA, valid, `pkt_len` = MAX (babble): drop the byte, go to NAK, `out_nak_o` = 1. The packet will roll back.
  - NAK, valid: discard the byte.
  - Any state, `out_err_i`: `spec_ptr` ← `wr_ptr`, go to IDLE, `out_nak_o` = 0.
  - Any state, end (valid = 0, err = 0):
    - From DATA: tag the last written byte, `wr_ptr` ← `spec_ptr`, `cnt` += `pkt_len`.
    - From NAK: `spec_ptr` ← `wr_ptr`; `out_nak_o` stays latched until the next packet start.
    - Go to IDLE.
  - A zero-length packet (end while in IDLE) commits nothing.
- Free space = `FIFO_DEPTH` − `cnt`. Speculative bytes never overlap committed data, because admission guarantees room.
- App beat, with n = min(`cnt`, APP_BYTES):
  - With the macro enabled, n is further truncated at the first last-tagged byte.
  - `app_out_valid_o` = (n = APP_BYTES) or (macro enabled and a last tag lies within the first n bytes).
  - `keep` = n low bits set. `last` = tag of byte n−1.
  - Consume: `rd_ptr` += n (mod `FIFO_DEPTH`), `cnt` −= n.
- A commit and a consume in the same cycle both apply: `cnt` += `pkt_len` − n.

## Timing
- Reset values:
  - All pointers and counters 0, state IDLE.
  - `out_nak_o` 0, `out_empty_o` 1, `out_full_o` 0.
  - `app_out_valid_o` 0, `app_out_keep_o` 0, `app_out_last_o` 0, `app_out_data_o` 0 (the array is cleared).
- `rst_i` mid-packet discards all data, committed and speculative.
- Committed bytes are visible to the app: `app_out_valid_o` rises the cycle after the commit edge.
- App outputs are combinational from registers. Zero-cycle throughput: one beat per clock when `app_out_ready_i` is held high.
- `out_full_o` and `out_empty_o` are combinational from `cnt`. `out_full_o` reflects a consume in the cycle after it.
- `out_nak_o` updates on the `out_ready_i` edge.

## Configuration
- `OUT_PKT_FIFO_LAST_EN` defined:
  - Last tags are stored.
  - A packet end flushes a partial beat with reduced keep and `app_out_last_o` = 1.
  - Beats never straddle packets.
- Not defined:
  - No tag storage; `app_out_last_o` is tied 0.
  - Beats are emitted only when `cnt` ≥ APP_BYTES, so bytes pack across packet boundaries and `keep` is all ones.

## Structure
- Package `out_pkt_fifo_pkg`:
  - State localparams `ST_IDLE`/`ST_DATA`/`ST_NAK`.
  - `ceil_log2` function.
  - `APP_BYTES` legality check.
- Sub-module `out_pkt_fifo_pack`: read-side beat assembly (n, keep, last, pointer advance). It takes the array and `rd_ptr`/`cnt` as inputs.

## Test plan
- APP_BYTES=1, 5-byte packet 0x01..0x05 then end → nothing visible before the commit edge; then 01..05 in order, `last` on 05.
- Packet of 3 bytes then `out_err_i` → `cnt` stays 0, `out_empty_o` stays 1; the next packet 0xAA is delivered alone.
- FIFO_DEPTH=128, MAX=64, 65 bytes committed (free 63) → next packet NAKed whole: `out_nak_o` = 1, no bytes stored. Drain 1 byte → next packet accepted, `out_nak_o` returns to 0.
- APP_BYTES=4 with macro enabled, 6-byte packet → beat 1 keep=1111, last=0; beat 2 keep=0011, last=1, data[15:0] = bytes 5,4.
- Same stimulus without the macro → one beat of 4 bytes; 2 bytes remain until the next packet supplies 2 more.
- FIFO_DEPTH=72, repeated 64-byte packets drained concurrently → pointers wrap past 71 with no lost or duplicated bytes. A commit in the same cycle as a consume gives correct `cnt`.

Source files
------------

// File: rtl/out_pkt_fifo_pkg.sv
// Shared FSM encodings and elaboration helpers for the packet-aware USB OUT FIFO.
package out_pkt_fifo_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_NAK  = 2'd2;

  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit params_legal(input int app_bytes, input int max_pkt, input int depth);
    return ((app_bytes == 1) || (app_bytes == 2) || (app_bytes == 4)) &&
           (max_pkt >= 8) && (max_pkt <= 64) && (depth >= max_pkt);
  endfunction

endpackage

// File: rtl/out_pkt_fifo_pack.sv
// Read-side beat assembly: gathers up to APP_BYTES committed bytes from rd_ptr and computes the pointer advance.
// Latency: purely combinational from the storage array, rd_ptr and cnt.
// Backpressure: a beat is only consumed (take_o nonzero) when valid_o and ready_i are both high.
module out_pkt_fifo_pack
  import out_pkt_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 128,
  parameter int APP_BYTES  = 1,
  parameter int PTR_W      = 7,
  parameter int CNT_W      = 8
) (
  input  logic [FIFO_DEPTH-1:0][7:0] mem_i,
`ifdef OUT_PKT_FIFO_LAST_EN
  input  logic [FIFO_DEPTH-1:0]      tag_i,
`endif
  input  logic [PTR_W-1:0]           rd_ptr_i,
  input  logic [CNT_W-1:0]           cnt_i,
  input  logic                       ready_i,
  output logic [8*APP_BYTES-1:0]     data_o,
  output logic [APP_BYTES-1:0]       keep_o,
  output logic                       last_o,
  output logic                       valid_o,
  output logic [CNT_W-1:0]           take_o,
  output logic [PTR_W-1:0]           rd_ptr_d_o
);

  localparam int SW = PTR_W + 1;

  logic [CNT_W-1:0] n;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    nxt;
  logic [PTR_W-1:0] idx;
  logic             stop;

  always_comb begin
    data_o = '0;
    keep_o = '0;
    last_o = 1'b0;
    n      = '0;
    stop   = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < APP_BYTES; i++) begin
      sum = {1'b0, rd_ptr_i} + SW'(i);
      if (sum >= SW'(FIFO_DEPTH)) sum = sum - SW'(FIFO_DEPTH);
      idx = sum[PTR_W-1:0];
      if (!stop && (CNT_W'(i) < cnt_i)) begin
        data_o[8*i +: 8] = mem_i[idx];
        keep_o[i]        = 1'b1;
        n                = CNT_W'(i + 1);
`ifdef OUT_PKT_FIFO_LAST_EN
        // A packet end closes the beat so beats never straddle packets.
        if (tag_i[idx]) begin
          stop   = 1'b1;
          last_o = 1'b1;
        end
`endif
      end
    end
    valid_o = (n == CNT_W'(APP_BYTES)) || last_o;
    take_o  = (valid_o && ready_i) ? n : '0;
    nxt     = {1'b0, rd_ptr_i} + SW'(take_o);
    if (nxt >= SW'(FIFO_DEPTH)) nxt = nxt - SW'(FIFO_DEPTH);
    rd_ptr_d_o = nxt[PTR_W-1:0];
  end

endmodule

// File: rtl/out_pkt_fifo.sv
// Packet-aware USB OUT FIFO: speculative SIE writes committed or rolled back per packet; OUT_PKT_FIFO_LAST_EN adds packet-end tags.
// Latency: a committed packet is visible to the application the cycle after its end strobe.
// Backpressure: SIE packets are NAKed whole unless a max-size packet fits; app beats hold until valid & ready.
module out_pkt_fifo
  import out_pkt_fifo_pkg::*;
#(
  parameter int OUT_MAXPACKETSIZE = 64,
  parameter int FIFO_DEPTH        = 128,
  parameter int APP_BYTES         = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             out_data_i,
  input  logic                   out_valid_i,
  input  logic                   out_err_i,
  input  logic                   out_ready_i,
  output logic                   out_nak_o,
  output logic                   out_empty_o,
  output logic                   out_full_o,
  output logic [8*APP_BYTES-1:0] app_out_data_o,
  output logic [APP_BYTES-1:0]   app_out_keep_o,
  output logic                   app_out_last_o,
  output logic                   app_out_valid_o,
  input  logic                   app_out_ready_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? ceil_log2(FIFO_DEPTH) : 1;
  localparam int CNT_W = ceil_log2(FIFO_DEPTH + 1);
  localparam int LEN_W = ceil_log2(OUT_MAXPACKETSIZE + 1);

  if (!params_legal(APP_BYTES, OUT_MAXPACKETSIZE, FIFO_DEPTH)) begin : g_bad_params
    $error("out_pkt_fifo: illegal APP_BYTES / OUT_MAXPACKETSIZE / FIFO_DEPTH");
  end

  logic [1:0]                  state_q, state_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            spec_ptr_q, spec_ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d, free, take;
  logic [LEN_W-1:0]            pkt_len_q, pkt_len_d;
  logic                        nak_q, nak_d;
  logic                        wr_en, commit;
  logic [FIFO_DEPTH-1:0][7:0]  mem_q;
`ifdef OUT_PKT_FIFO_LAST_EN
  logic [FIFO_DEPTH-1:0]       tag_q;
  logic [PTR_W-1:0]            spec_prev;

  assign spec_prev = (spec_ptr_q == '0) ? PTR_W'(FIFO_DEPTH - 1) : spec_ptr_q - PTR_W'(1);
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign free        = CNT_W'(FIFO_DEPTH) - cnt_q;
  assign out_empty_o = (cnt_q == '0);
  assign out_full_o  = (free < CNT_W'(OUT_MAXPACKETSIZE));
  assign out_nak_o   = nak_q;

  always_comb begin
    state_d    = state_q;
    spec_ptr_d = spec_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pkt_len_d  = pkt_len_q;
    nak_d      = nak_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    if (out_ready_i) begin
      if (out_err_i) begin
        spec_ptr_d = wr_ptr_q;
        state_d    = ST_IDLE;
        nak_d      = 1'b0;
      end else if (out_valid_i) begin
        case (state_q)
          ST_IDLE: begin
            // Admit only if a full max-size packet fits, so speculative bytes never hit committed data.
            if (free >= CNT_W'(OUT_MAXPACKETSIZE)) begin
              wr_en      = 1'b1;
              spec_ptr_d = ptr_inc(spec_ptr_q);
              pkt_len_d  = LEN_W'(1);
              state_d    = ST_DATA;
              nak_d      = 1'b0;
            end else begin
              state_d = ST_NAK;
              nak_d   = 1'b1;
            end
          end
          ST_DATA: begin
            if (pkt_len_q < LEN_W'(OUT_MAXPACKETSIZE)) begin
              wr_en      = 1'b1;
              spec_ptr_d = ptr_inc(spec_ptr_q);
              pkt_len_d  = pkt_len_q + LEN_W'(1);
            end else begin
              state_d = ST_NAK;
              nak_d   = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        if (state_q == ST_DATA) begin
          commit   = 1'b1;
          wr_ptr_d = spec_ptr_q;
        end else if (state_q == ST_NAK) begin
          spec_ptr_d = wr_ptr_q;
        end
        state_d = ST_IDLE;
      end
    end
    cnt_d = cnt_q + (commit ? CNT_W'(pkt_len_q) : '0) - take;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      spec_ptr_q <= '0;
      cnt_q      <= '0;
      pkt_len_q  <= '0;
      nak_q      <= 1'b0;
      mem_q      <= '0;
`ifdef OUT_PKT_FIFO_LAST_EN
      tag_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      spec_ptr_q <= spec_ptr_d;
      cnt_q      <= cnt_d;
      pkt_len_q  <= pkt_len_d;
      nak_q      <= nak_d;
      if (wr_en) mem_q[spec_ptr_q] <= out_data_i;
`ifdef OUT_PKT_FIFO_LAST_EN
      if (wr_en) tag_q[spec_ptr_q] <= 1'b0;
      if (commit) tag_q[spec_prev] <= 1'b1;
`endif
    end
  end

  out_pkt_fifo_pack #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .APP_BYTES  (APP_BYTES),
    .PTR_W      (PTR_W),
    .CNT_W      (CNT_W)
  ) u_pack (
    .mem_i      (mem_q),
`ifdef OUT_PKT_FIFO_LAST_EN
    .tag_i      (tag_q),
`endif
    .rd_ptr_i   (rd_ptr_q),
    .cnt_i      (cnt_q),
    .ready_i    (app_out_ready_i),
    .data_o     (app_out_data_o),
    .keep_o     (app_out_keep_o),
    .last_o     (app_out_last_o),
    .valid_o    (app_out_valid_o),
    .take_o     (take),
    .rd_ptr_d_o (rd_ptr_d)
  );

endmodule

// File: tb/tb_out_pkt_fifo.sv
// Scoreboarded bench for out_pkt_fifo: a 128-deep single-byte instance and a 72-deep four-byte instance.
module tb_out_pkt_fifo;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

`ifdef OUT_PKT_FIFO_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a_out_data, b_out_data;
  logic        a_out_valid, a_out_err, a_out_ready, b_out_valid, b_out_err, b_out_ready;
  logic        a_nak, a_empty, a_full, b_nak, b_empty, b_full;
  logic [7:0]  a_app_data;
  logic [0:0]  a_keep;
  logic [31:0] b_app_data;
  logic [3:0]  b_keep;
  logic        a_last, a_app_valid, a_app_ready, b_last, b_app_valid, b_app_ready;

  int    errors = 0;
  int    checks = 0;
  beat_t qa[$];
  beat_t qb[$];
  beat_t ea, eb;

  out_pkt_fifo #(.OUT_MAXPACKETSIZE(64), .FIFO_DEPTH(128), .APP_BYTES(1)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .out_data_i(a_out_data), .out_valid_i(a_out_valid), .out_err_i(a_out_err), .out_ready_i(a_out_ready),
    .out_nak_o(a_nak), .out_empty_o(a_empty), .out_full_o(a_full),
    .app_out_data_o(a_app_data), .app_out_keep_o(a_keep), .app_out_last_o(a_last),
    .app_out_valid_o(a_app_valid), .app_out_ready_i(a_app_ready)
  );

  out_pkt_fifo #(.OUT_MAXPACKETSIZE(64), .FIFO_DEPTH(72), .APP_BYTES(4)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .out_data_i(b_out_data), .out_valid_i(b_out_valid), .out_err_i(b_out_err), .out_ready_i(b_out_ready),
    .out_nak_o(b_nak), .out_empty_o(b_empty), .out_full_o(b_full),
    .app_out_data_o(b_app_data), .app_out_keep_o(b_keep), .app_out_last_o(b_last),
    .app_out_valid_o(b_app_valid), .app_out_ready_i(b_app_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input logic [31:0] d, input logic [3:0] k,
                            input logic l, input beat_t e);
    logic [31:0] m;
    m = {{8{e.keep[3]}}, {8{e.keep[2]}}, {8{e.keep[1]}}, {8{e.keep[0]}}};
    checks++;
    if (((d & m) !== (e.data & m)) || (k !== e.keep) || (l !== e.last)) begin
      errors++;
      $display("FAIL %s: got data=0x%08h keep=%b last=%b, want data=0x%08h keep=%b last=%b",
               name, d & m, k, l, e.data & m, e.keep, e.last);
    end
  endtask

  task automatic push_a(input logic [7:0] d, input logic lst);
    beat_t e;
    e.data = {24'd0, d};
    e.keep = 4'b0001;
    e.last = lst & LAST_EN;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] d, input logic [3:0] k, input logic lst);
    beat_t e;
    e.data = d;
    e.keep = k;
    e.last = lst & LAST_EN;
    qb.push_back(e);
  endtask

  // One SIE strobe; entered and left 1 time unit after a rising edge.
  task automatic a_strobe(input logic v, input logic e, input logic [7:0] d);
    a_out_valid = v; a_out_err = e; a_out_data = d; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_valid = 1'b0; a_out_err = 1'b0; a_out_ready = 1'b0;
  endtask

  task automatic b_strobe(input logic v, input logic e, input logic [7:0] d);
    b_out_valid = v; b_out_err = e; b_out_data = d; b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_valid = 1'b0; b_out_err = 1'b0; b_out_ready = 1'b0;
  endtask

  task automatic wait_a();
    for (int t = 0; t < 400 && qa.size() != 0; t++) @(posedge clk);
    #1;
    check("a_drain_left", 32'(qa.size()), 32'd0);
  endtask

  task automatic wait_b();
    for (int t = 0; t < 400 && qb.size() != 0; t++) @(posedge clk);
    #1;
    check("b_drain_left", 32'(qb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && a_app_valid && a_app_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_beat: got unexpected data=0x%02h, want no beat", a_app_data);
      end else begin
        ea = qa.pop_front();
        check_beat("a_beat", {24'd0, a_app_data}, {3'd0, a_keep}, a_last, ea);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_app_valid && b_app_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_beat: got unexpected data=0x%08h keep=%b, want no beat", b_app_data, b_keep);
      end else begin
        eb = qb.pop_front();
        check_beat("b_beat", b_app_data, b_keep, b_last, eb);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    a_out_data = '0; a_out_valid = 1'b0; a_out_err = 1'b0; a_out_ready = 1'b0; a_app_ready = 1'b1;
    b_out_data = '0; b_out_valid = 1'b0; b_out_err = 1'b0; b_out_ready = 1'b0; b_app_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("a_rst_nak", a_nak, 0);
    check("a_rst_empty", a_empty, 1);
    check("a_rst_full", a_full, 0);
    check("a_rst_valid", a_app_valid, 0);
    check("a_rst_keep", a_keep, 0);
    check("a_rst_last", a_last, 0);
    check("a_rst_data", a_app_data, 0);
    check("b_rst_valid", b_app_valid, 0);
    check("b_rst_keep", b_keep, 0);
    check("b_rst_data", b_app_data, 0);
    check("b_rst_empty", b_empty, 1);

    // 5-byte packet: invisible until the end strobe commits it.
    for (int i = 1; i <= 5; i++) a_strobe(1'b1, 1'b0, 8'(i));
    check("a_hidden_valid", a_app_valid, 0);
    check("a_hidden_empty", a_empty, 1);
    a_strobe(1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 5; i++) push_a(8'(i), i == 5);
    wait_a();
    check("a_drained_empty", a_empty, 1);

    // Aborted packet rolls back; the following single byte is delivered alone.
    for (int i = 0; i < 3; i++) a_strobe(1'b1, 1'b0, 8'(8'h10 + i));
    a_strobe(1'b0, 1'b1, 8'h00);
    check("a_err_empty", a_empty, 1);
    repeat (2) @(posedge clk);
    #1 check("a_err_valid", a_app_valid, 0);
    a_strobe(1'b1, 1'b0, 8'hAA);
    a_strobe(1'b0, 1'b0, 8'h00);
    push_a(8'hAA, 1'b1);
    wait_a();

    // Fill to 65 committed bytes, then a packet must be NAKed whole.
    a_app_ready = 1'b0;
    for (int i = 0; i < 64; i++) a_strobe(1'b1, 1'b0, 8'(64 + i));
    a_strobe(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 64; i++) push_a(8'(64 + i), i == 63);
    a_strobe(1'b1, 1'b0, 8'hC5);
    a_strobe(1'b0, 1'b0, 8'h00);
    push_a(8'hC5, 1'b1);
    check("a_full_65", a_full, 1);
    check("a_nak_before", a_nak, 0);
    a_strobe(1'b1, 1'b0, 8'h77);
    check("a_nak_set", a_nak, 1);
    a_strobe(1'b1, 1'b0, 8'h78);
    a_strobe(1'b0, 1'b0, 8'h00);
    check("a_nak_latched", a_nak, 1);
    a_app_ready = 1'b1;
    @(posedge clk);
    #1 a_app_ready = 1'b0;
    check("a_full_after_drain1", a_full, 0);
    a_strobe(1'b1, 1'b0, 8'hB0);
    check("a_nak_cleared", a_nak, 0);
    a_strobe(1'b1, 1'b0, 8'hB1);
    a_strobe(1'b0, 1'b0, 8'h00);
    push_a(8'hB0, 1'b0);
    push_a(8'hB1, 1'b1);
    a_app_ready = 1'b1;
    wait_a();
    check("a_final_empty", a_empty, 1);

    // Four-byte beats: 6-byte packet, then 2 more bytes.
    for (int i = 0; i < 6; i++) b_strobe(1'b1, 1'b0, 8'(8'h21 + i));
    b_strobe(1'b0, 1'b0, 8'h00);
    push_b(32'h24232221, 4'hF, 1'b0);
    if (LAST_EN) push_b(32'h00002625, 4'h3, 1'b1);
    wait_b();
    check("b_partial_valid", b_app_valid, 0);
    check("b_partial_empty", b_empty, LAST_EN ? 32'd1 : 32'd0);
    b_strobe(1'b1, 1'b0, 8'h27);
    b_strobe(1'b1, 1'b0, 8'h28);
    b_strobe(1'b0, 1'b0, 8'h00);
    if (LAST_EN) push_b(32'h00002827, 4'h3, 1'b1);
    else         push_b(32'h28272625, 4'hF, 1'b0);
    wait_b();
    check("b_pair_empty", b_empty, 1);

    // 64-byte packets in a 72-deep store; commit coincides with a consume for k > 0.
    for (int k = 0; k < 4; k++) begin
      b_app_ready = 1'b0;
      for (int i = 0; i < 64; i++) b_strobe(1'b1, 1'b0, 8'(k * 64 + i));
      b_app_ready = 1'b1;
      b_strobe(1'b0, 1'b0, 8'h00);
      for (int j = 0; j < 16; j++) begin
        w = {8'(k * 64 + 4 * j + 3), 8'(k * 64 + 4 * j + 2), 8'(k * 64 + 4 * j + 1), 8'(k * 64 + 4 * j)};
        push_b(w, 4'hF, j == 15);
      end
      check("b_full_commit", b_full, 1);
      repeat ((k == 0) ? 14 : 15) @(posedge clk);
      #1 check("b_room_again", b_full, 0);
    end
    wait_b();
    repeat (3) @(posedge clk);
    #1;
    check("b_wrap_empty", b_empty, 1);
    check("b_wrap_valid", b_app_valid, 0);

    // Babble: 65th byte NAKs and the whole packet rolls back.
    for (int i = 0; i < 64; i++) b_strobe(1'b1, 1'b0, 8'(8'h80 + i));
    check("b_nak_at_max", b_nak, 0);
    b_strobe(1'b1, 1'b0, 8'hFF);
    check("b_nak_babble", b_nak, 1);
    b_strobe(1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("b_babble_empty", b_empty, 1);
    check("b_babble_valid", b_app_valid, 0);
    b_strobe(1'b1, 1'b0, 8'hD0);
    check("b_nak_clear", b_nak, 0);
    for (int i = 1; i < 4; i++) b_strobe(1'b1, 1'b0, 8'(8'hD0 + i));
    b_strobe(1'b0, 1'b0, 8'h00);
    push_b(32'hD3D2D1D0, 4'hF, 1'b1);
    wait_b();

    // Reset in the middle of a packet discards it.
    for (int i = 0; i < 3; i++) a_strobe(1'b1, 1'b0, 8'(8'h55 + i));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    a_strobe(1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_mid_empty", a_empty, 1);
    check("a_rst_mid_valid", a_app_valid, 0);

    check("qa_leftover", 32'(qa.size()), 32'd0);
    check("qb_leftover", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
